// File: rtl/bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Digits needed to cover the full range of an n-bit unsigned value: ceil(n*log10(2))
    function automatic int min_digits(input int n_bits);
        return (n_bits * 30103 + 99999) / 100000;
    endfunction

    // Width of the shift-step counter; it counts 0..n_bits-1
    function automatic int cnt_width(input int n_bits);
        return $clog2(n_bits);
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correction is local to the digit; the carry out of it is produced by the following shift
    assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one shift-and-adjust step per clock,
// with valid/ready handshakes on both the operand and the result side.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int N_BITS   = 16,
    parameter int N_DIGITS = 5,
    parameter bit SIGNED   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  sign_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = cnt_width(N_BITS);

    if (N_BITS < 4 || N_BITS > 32 || N_DIGITS < 1) begin : g_bad_param
        $fatal(1, "bin2bcd_seq: N_BITS must be 4..32 and N_DIGITS >= 1");
    end

    state_e             state_q, state_d;
    logic [N_BITS-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic               sign_q,  sign_d;
    logic               ovf_q,   ovf_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [N_BITS-1:0]  mag;
    logic               neg;

    // Per-digit +3 correction applied to the current BCD accumulator
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_add3_digit u_add3 (
            .din  (bcd_q[4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    // Operand magnitude; the most negative value negates to itself, which is the
    // correct unsigned magnitude 2^(N_BITS-1)
    always_comb begin
        neg = SIGNED && bin_in[N_BITS-1];
        mag = neg ? -bin_in : bin_in;
    end

    // Next-state and datapath updates for IDLE -> CONV -> DONE
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = mag;
                    sign_d  = neg;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // The MSB of the corrected top digit is lost by the shift; remember it as overflow
                {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                ovf_d = ovf_q | bcd_adj[BCD_W-1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_BITS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;
    assign ovf       = ovf_q;

endmodule
